// File: rtl/ibex_mem_slave_pkg.sv
// Shared types and limits for the ibex memory slave model.
// Holds the response record, the parameter limits and the byte-merge helper.
package ibex_mem_slave_pkg;

  localparam int MAX_GNT_DELAY      = 15;
  localparam int MAX_RVALID_LATENCY = 8;
  localparam int MAX_DATA_WIDTH     = 64;
  localparam int MAX_BE_WIDTH       = MAX_DATA_WIDTH / 8;
  // Wide enough to count up to MAX_GNT_DELAY.
  localparam int CNT_WIDTH          = 4;

  // One response slot travelling down the fixed-latency return path.
  typedef struct packed {
    logic                      valid;
    logic [MAX_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } mem_resp_t;

  // Replace the bytes of old_word selected by be with the bytes of new_word.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ibex_mem_slave_resp_pipe.sv
// Fixed-latency response return path: a DEPTH-deep shift register of
// response slots. Reset flushes every slot so nothing in flight survives.
module ibex_mem_slave_resp_pipe
  import ibex_mem_slave_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  mem_resp_t resp_in,
  output mem_resp_t resp_out
);

  mem_resp_t stage_r [DEPTH];

  // Advance every slot one stage per cycle; flush all slots on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= resp_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign resp_out = stage_r[DEPTH-1];

endmodule

// File: rtl/ibex_mem_slave_model.sv
// Behavioural memory slave for the ibex request/grant/rvalid protocol.
// Grant is delayed by GNT_DELAY held-request cycles; every grant yields one
// response RVALID_LATENCY cycles later, in grant order.
// Optional feature: define IBEX_MEM_SLAVE_ERR_INJ_EN to add the err_inject
// input, which forces the granted access to behave as out of range.
module ibex_mem_slave_model
  import ibex_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WORDS      = 256,
  parameter int GNT_DELAY      = 0,
  parameter int RVALID_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    request,
  output logic                    grant,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
`ifdef IBEX_MEM_SLAVE_ERR_INJ_EN
  input  logic                    err_inject,
`endif
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int OFFS      = $clog2(BE_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - OFFS;
  localparam int CMP_WIDTH = IDX_WIDTH + 1;
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [CNT_WIDTH-1:0]      wait_cnt_r;
  logic [IDX_WIDTH-1:0]      word_idx_s;
  logic                      in_range_s;
  logic                      access_ok_s;
  logic [MEM_AW-1:0]         mem_addr_s;
  logic [DATA_WIDTH-1:0]     mem_r [MEM_WORDS];
  logic [MAX_DATA_WIDTH-1:0] merged_s;
  mem_resp_t                 resp_in_s;
  mem_resp_t                 resp_out_s;
  logic                      unused_bits_s;

  // Address decode: byte offset bits are dropped, the rest is the word index.
  assign word_idx_s  = addr[ADDR_WIDTH-1:OFFS];
  assign in_range_s  = ({1'b0, word_idx_s} < CMP_WIDTH'(MEM_WORDS));
  assign mem_addr_s  = word_idx_s[MEM_AW-1:0];

`ifdef IBEX_MEM_SLAVE_ERR_INJ_EN
  assign access_ok_s = in_range_s & ~err_inject;
`else
  assign access_ok_s = in_range_s;
`endif

  // Grant once the request has been held for GNT_DELAY cycles; never in reset.
  assign grant = request & ~reset & (wait_cnt_r == CNT_WIDTH'(GNT_DELAY));

  // Count held-but-ungranted request cycles, saturating at GNT_DELAY.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (!request || grant) begin
      wait_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (wait_cnt_r != CNT_WIDTH'(GNT_DELAY)) begin
      wait_cnt_r <= wait_cnt_r + CNT_WIDTH'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Byte-enable merge of the write data into the currently stored word.
  always_comb begin
    merged_s = byte_merge(MAX_DATA_WIDTH'(mem_r[mem_addr_s]),
                          MAX_DATA_WIDTH'(wdata),
                          MAX_BE_WIDTH'(be));
  end

  // Commit an in-range granted write at the grant edge; memory has no reset.
  always_ff @(posedge clock) begin
    if (grant && we && access_ok_s) begin
      mem_r[mem_addr_s] <= merged_s[DATA_WIDTH-1:0];
    end
  end

  // Build the response for the access granted this cycle (idle slot otherwise).
  always_comb begin
    resp_in_s = '0;
    if (grant) begin
      resp_in_s.valid = 1'b1;
      if (!access_ok_s) begin
        resp_in_s.error = 1'b1;
      end else if (!we) begin
        resp_in_s.rdata = MAX_DATA_WIDTH'(mem_r[mem_addr_s]);
      end else begin
        resp_in_s.rdata = {MAX_DATA_WIDTH{1'b0}};
      end
    end else begin
      resp_in_s = '0;
    end
  end

  ibex_mem_slave_resp_pipe #(
    .DEPTH (RVALID_LATENCY)
  ) u_resp_pipe (
    .clock    (clock),
    .reset    (reset),
    .resp_in  (resp_in_s),
    .resp_out (resp_out_s)
  );

  // Outputs come straight from the pipe registers, held quiet during reset.
  assign rvalid = resp_out_s.valid & ~reset;
  assign rdata  = resp_out_s.rdata[DATA_WIDTH-1:0] & {DATA_WIDTH{~reset}};
  assign error  = resp_out_s.error & ~reset;

  assign unused_bits_s = ^{addr[OFFS-1:0], resp_out_s.rdata, merged_s};

endmodule

// File: tb/tb_ibex_mem_slave_model.sv
// Randomized + directed bench for ibex_mem_slave_model. Three instances cover
// (GNT_DELAY,RVALID_LATENCY) = (0,1), (3,2), (0,4). The reference model is a
// word array plus a per-cycle table of expected responses keyed by due cycle.
module tb_ibex_mem_slave_model;

  localparam int NCFG = 3;
  localparam int GD  [NCFG] = '{0, 3, 0};
  localparam int LAT [NCFG] = '{1, 2, 4};
  localparam int NW = 256;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_s    [NCFG];
  logic        grant_s  [NCFG];
  logic [31:0] addr_s   [NCFG];
  logic        we_s     [NCFG];
  logic [3:0]  be_s     [NCFG];
  logic [31:0] wdata_s  [NCFG];
  logic        rvalid_s [NCFG];
  logic [31:0] rdata_s  [NCFG];
  logic        error_s  [NCFG];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] mdl   [NCFG][NW];
  logic        exp_v [NCFG][16];
  logic [31:0] exp_d [NCFG][16];
  logic        exp_e [NCFG][16];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  ibex_mem_slave_model #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256),
                         .GNT_DELAY(0), .RVALID_LATENCY(1)) u_dut0 (
    .clock(clock), .reset(reset), .request(req_s[0]), .grant(grant_s[0]),
    .addr(addr_s[0]), .we(we_s[0]), .be(be_s[0]), .wdata(wdata_s[0]),
    .rvalid(rvalid_s[0]), .rdata(rdata_s[0]), .error(error_s[0]));

  ibex_mem_slave_model #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256),
                         .GNT_DELAY(3), .RVALID_LATENCY(2)) u_dut1 (
    .clock(clock), .reset(reset), .request(req_s[1]), .grant(grant_s[1]),
    .addr(addr_s[1]), .we(we_s[1]), .be(be_s[1]), .wdata(wdata_s[1]),
    .rvalid(rvalid_s[1]), .rdata(rdata_s[1]), .error(error_s[1]));

  ibex_mem_slave_model #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(256),
                         .GNT_DELAY(0), .RVALID_LATENCY(4)) u_dut2 (
    .clock(clock), .reset(reset), .request(req_s[2]), .grant(grant_s[2]),
    .addr(addr_s[2]), .we(we_s[2]), .be(be_s[2]), .wdata(wdata_s[2]),
    .rvalid(rvalid_s[2]), .rdata(rdata_s[2]), .error(error_s[2]));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Drop every expected response (reset discards in-flight traffic).
  task automatic clear_expect();
    for (int c = 0; c < NCFG; c++)
      for (int s = 0; s < 16; s++) begin
        exp_v[c][s] = 1'b0; exp_d[c][s] = 32'h0; exp_e[c][s] = 1'b0;
      end
  endtask

  // Apply a granted access to the model and schedule its response.
  task automatic model_grant(input int c, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d);
    int idx;
    int s;
    idx = int'(a >> 2);
    s = (cyc + LAT[c]) % 16;
    exp_v[c][s] = 1'b1;
    if (a >= 32'h400) begin
      exp_d[c][s] = 32'h0; exp_e[c][s] = 1'b1;
    end else if (w) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mdl[c][idx][8*i +: 8] = d[8*i +: 8];
      exp_d[c][s] = 32'h0; exp_e[c][s] = 1'b0;
    end else begin
      exp_d[c][s] = mdl[c][idx]; exp_e[c][s] = 1'b0;
    end
  endtask

  // Hold a request up to max_hold cycles; junk on the bus until the grant cycle.
  task automatic access(input int c, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input int max_hold);
    logic got;
    got = 1'b0;
    req_s[c] = 1'b1;
    for (int k = 0; k < max_hold && !got; k++) begin
      if (k < GD[c]) begin
        we_s[c] = 1'($urandom()); addr_s[c] = $urandom();
        be_s[c] = 4'($urandom()); wdata_s[c] = $urandom();
      end else begin
        we_s[c] = w; addr_s[c] = a; be_s[c] = b; wdata_s[c] = d;
      end
      @(negedge clock);
      check_val($sformatf("grant%0d", c), 64'(grant_s[c]), 64'(k == GD[c]));
      if (k == GD[c]) begin
        got = 1'b1;
        model_grant(c, w, a, b, d);
      end
      @(posedge clock); #1;
    end
    req_s[c] = 1'b0;
    if (!got) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    req_s[0] = 1'b1;
    clear_expect();
    repeat (n) begin
      @(negedge clock);
      check_val("grant_in_reset", 64'(grant_s[0]), 64'd0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    req_s[0] = 1'b0;
  endtask

  // Per-cycle response check for every instance against the due-cycle table.
  always @(negedge clock) begin
    int s;
    s = cyc % 16;
    for (int c = 0; c < NCFG; c++) begin
      check_val($sformatf("rvalid%0d", c), 64'(rvalid_s[c]), 64'(exp_v[c][s]));
      check_val($sformatf("rdata%0d", c), 64'(rdata_s[c]), 64'(exp_d[c][s]));
      check_val($sformatf("error%0d", c), 64'(error_s[c]), 64'(exp_e[c][s]));
      exp_v[c][s] = 1'b0; exp_d[c][s] = 32'h0; exp_e[c][s] = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    clear_expect();
    for (int c = 0; c < NCFG; c++) begin
      req_s[c] = 1'b0; addr_s[c] = 32'h0; we_s[c] = 1'b0;
      be_s[c] = 4'h0; wdata_s[c] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill every word of every instance so later reads are fully defined.
    for (int c = 0; c < NCFG; c++)
      for (int w = 0; w < NW; w++)
        access(c, 1'b1, 32'(w * 4), 4'hF, $urandom(), GD[c] + 1);
    idle(6);

    // Full write then read back at latency 1.
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1);
    @(negedge clock);
    check_val("rd_full", 64'(rdata_s[0]), 64'h0000_0000_DEAD_BEEF);
    @(posedge clock); #1;

    // Partial byte-enable write over the previous word.
    access(0, 1'b1, 32'h10, 4'h3, 32'h00001234, 1);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1);
    @(negedge clock);
    check_val("rd_partial", 64'(rdata_s[0]), 64'h0000_0000_DEAD_1234);
    @(posedge clock); #1;

    // Out-of-range read, then a normal read.
    access(0, 1'b0, 32'h400, 4'h0, 32'h0, 1);
    @(negedge clock);
    check_val("oor_err", 64'(error_s[0]), 64'd1);
    check_val("oor_rdata", 64'(rdata_s[0]), 64'd0);
    @(posedge clock); #1;
    access(0, 1'b0, 32'h0, 4'h0, 32'h0, 1);
    idle(3);

    // Grant delay 3: held request granted in 4th cycle; dropped one ignored.
    access(1, 1'b0, 32'h8, 4'h0, 32'h0, 4);
    idle(2);
    access(1, 1'b1, 32'h8, 4'hF, 32'h55AA55AA, 2);
    idle(5);
    access(1, 1'b0, 32'h8, 4'h0, 32'h0, 4);
    idle(4);

    // Latency 4: back-to-back reads return as consecutive pulses, in order.
    access(2, 1'b0, 32'h0, 4'h0, 32'h0, 1);
    access(2, 1'b0, 32'h4, 4'h0, 32'h0, 1);
    access(2, 1'b0, 32'h8, 4'h0, 32'h0, 1);
    @(posedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_val("b2b_rvalid", 64'(rvalid_s[2]), 64'd1);
      check_val("b2b_rdata", 64'(rdata_s[2]), 64'(mdl[2][k]));
      @(posedge clock); #1;
    end
    @(negedge clock);
    check_val("b2b_tail", 64'(rvalid_s[2]), 64'd0);
    @(posedge clock); #1;

    // Reset with two responses in flight; memory survives the reset.
    access(2, 1'b1, 32'h20, 4'hF, 32'hCAFE0001, 1);
    idle(5);
    access(2, 1'b0, 32'h0, 4'h0, 32'h0, 1);
    access(2, 1'b0, 32'h4, 4'h0, 32'h0, 1);
    do_reset(2);
    idle(6);
    access(2, 1'b0, 32'h20, 4'h0, 32'h0, 1);
    access(0, 1'b0, 32'h10, 4'h0, 32'h0, 1);
    idle(6);

    // Randomized traffic per instance, with drops and idle gaps.
    for (int c = 0; c < NCFG; c++) begin
      for (int n = 0; n < 150; n++) begin
        logic [31:0] a;
        int r;
        int hold;
        r = $urandom_range(0, 7);
        if (r == 0)      a = $urandom() | 32'h8000_0000;
        else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 4095));
        else             a = 32'($urandom_range(0, 1023));
        hold = GD[c] + 1;
        if (GD[c] > 0 && $urandom_range(0, 7) == 0) hold = $urandom_range(1, GD[c]);
        access(c, 1'($urandom()), a, 4'($urandom()), $urandom(), hold);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(8);
    end

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
